// File: rtl/i2c_sensor_poller.sv
// Sequencer that polls a register-mapped I2C sensor through an i2c_controller:
// one register-pointer write, then NUM_BYTES single-byte reads assembled MSB-first.
module i2c_sensor_poller #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h45,
    parameter logic [7:0] REG_PTR     = 8'h00,
    parameter int         NUM_BYTES   = 2,
    parameter int         POLL_PERIOD = 1000,
    parameter int         TIMEOUT     = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   poll_en,
    input  logic                   trigger,
    input  logic                   ctrl_ready,
    input  logic [7:0]             ctrl_data_out,
    output logic [6:0]             ctrl_addr,
    output logic [7:0]             ctrl_data_in,
    output logic                   ctrl_rw,
    output logic                   ctrl_enable,
    output logic [8*NUM_BYTES-1:0] sample,
    output logic                   sample_valid,
    output logic                   err,
    output logic                   busy
);

    localparam int SW = 8 * NUM_BYTES;
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(NUM_BYTES + 1);

    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] WD_LAST       = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_W,
        WAIT_ACC,
        WAIT_DONE,
        ISSUE_R,
        PUBLISH,
        ERROR
    } state_t;

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] wd_cnt;
    logic [IW-1:0] byte_idx;
    logic [SW-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            period_cnt   <= PERIOD_RELOAD;
            wd_cnt       <= '0;
            byte_idx     <= '0;
            shift_reg    <= '0;
            ctrl_addr    <= SLAVE_ADDR;
            ctrl_data_in <= '0;
            ctrl_rw      <= 1'b0;
            ctrl_enable  <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: pulses default low here so each branch only states when they fire.
            sample_valid <= 1'b0;
            err          <= 1'b0;
            wd_cnt       <= wd_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (trigger || (poll_en && period_cnt == '0)) begin
                        state <= ISSUE_W;
                        busy  <= 1'b1;
                    end else if (poll_en) begin
                        period_cnt <= period_cnt - 1'b1;
                    end
                end

                ISSUE_W: begin
                    if (ctrl_ready) begin
                        ctrl_enable  <= 1'b1;
                        ctrl_rw      <= 1'b0;
                        ctrl_data_in <= REG_PTR;
                        state        <= WAIT_ACC;
                        wd_cnt       <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state  <= ERROR;
                        wd_cnt <= '0;
                    end
                end

                WAIT_ACC: begin
                    if (!ctrl_ready) begin
                        ctrl_enable <= 1'b0;
                        state       <= WAIT_DONE;
                        wd_cnt      <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state  <= ERROR;
                        wd_cnt <= '0;
                    end
                end

                WAIT_DONE: begin
                    if (ctrl_ready) begin
                        wd_cnt <= '0;
                        if (!ctrl_rw) begin
                            state <= ISSUE_R;
                        end else begin
                            // Truncating cast drops the oldest byte off the top.
                            shift_reg <= SW'({shift_reg, ctrl_data_out});
                            byte_idx  <= byte_idx + 1'b1;
                            if (byte_idx == IDX_LAST) begin
                                sample       <= SW'({shift_reg, ctrl_data_out});
                                sample_valid <= 1'b1;
                                state        <= PUBLISH;
                            end else begin
                                state <= ISSUE_R;
                            end
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        state  <= ERROR;
                        wd_cnt <= '0;
                    end
                end

                ISSUE_R: begin
                    wd_cnt      <= '0;
                    ctrl_enable <= 1'b1;
                    ctrl_rw     <= 1'b1;
                    state       <= WAIT_ACC;
                end

                PUBLISH: begin
                    wd_cnt     <= '0;
                    busy       <= 1'b0;
                    period_cnt <= PERIOD_RELOAD;
                    byte_idx   <= '0;
                    state      <= IDLE;
                end

                ERROR: begin
                    wd_cnt      <= '0;
                    err         <= 1'b1;
                    ctrl_enable <= 1'b0;
                    busy        <= 1'b0;
                    period_cnt  <= PERIOD_RELOAD;
                    byte_idx    <= '0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Scoreboard bench for i2c_sensor_poller: a behavioural controller model answers
// requests, stimulus pushes expected transactions/samples, a monitor pops and compares.
module tb_i2c_sensor_poller;

    localparam int         NB      = 2;
    localparam int         PERIOD  = 50;
    localparam int         TMO     = 100;
    localparam logic [6:0] ADDR    = 7'h45;
    localparam logic [7:0] PTR     = 8'h00;

    logic            clk = 1'b0;
    logic            rst;
    logic            poll_en;
    logic            trigger;
    logic            ctrl_ready;
    logic [7:0]      ctrl_data_out;
    logic [6:0]      ctrl_addr;
    logic [7:0]      ctrl_data_in;
    logic            ctrl_rw;
    logic            ctrl_enable;
    logic [8*NB-1:0] sample;
    logic            sample_valid;
    logic            err;
    logic            busy;

    i2c_sensor_poller #(
        .SLAVE_ADDR (ADDR),
        .REG_PTR    (PTR),
        .NUM_BYTES  (NB),
        .POLL_PERIOD(PERIOD),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .poll_en      (poll_en),
        .trigger      (trigger),
        .ctrl_ready   (ctrl_ready),
        .ctrl_data_out(ctrl_data_out),
        .ctrl_addr    (ctrl_addr),
        .ctrl_data_in (ctrl_data_in),
        .ctrl_rw      (ctrl_rw),
        .ctrl_enable  (ctrl_enable),
        .sample       (sample),
        .sample_valid (sample_valid),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [7:0] data;
        logic       chk_data;
    } txn_t;

    typedef struct {
        logic            is_err;
        logic [8*NB-1:0] val;
    } evt_t;

    txn_t       exp_txn[$];
    evt_t       exp_evt[$];
    logic [7:0] rd_bytes[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model / monitor bookkeeping
    int mode = 0;          // 0 normal, 1 never accepts, 2 ready held low
    int rise_cyc = 0;
    int en_rises = 0;
    int en_rise_cyc = 0;
    int busy_rises = 0;
    int busy_rise_cyc = 0;
    int sv_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expire(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget exhausted at cycle %0d", nm, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Controller model: ready drops 2 cycles after a request, rises 20 cycles later.
    initial begin
        int   st  = 0;
        int   cnt = 0;
        logic rw  = 1'b0;
        ctrl_ready    = 1'b1;
        ctrl_data_out = 8'h00;
        forever begin
            @(negedge clk);
            case (st)
                0: begin
                    ctrl_ready = (mode != 2);
                    if (mode == 0 && ctrl_enable && ctrl_ready) begin
                        rw  = ctrl_rw;
                        cnt = 2;
                        st  = 1;
                    end
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        ctrl_ready = 1'b0;
                        cnt = 20;
                        st  = 2;
                    end
                end
                default: begin
                    cnt--;
                    if (cnt == 0) begin
                        if (rw) ctrl_data_out = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hEE;
                        ctrl_ready = 1'b1;
                        rise_cyc   = cyc;
                        st         = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: compares requests and published results against the scoreboard queues.
    initial begin
        logic       prev_en   = 1'b0;
        logic       prev_busy = 1'b0;
        logic [6:0] h_addr    = '0;
        logic       h_rw      = 1'b0;
        logic [7:0] h_data    = '0;
        txn_t       t;
        evt_t       e;
        forever begin
            @(negedge clk);
            if (ctrl_enable && !prev_en) begin
                en_rises++;
                en_rise_cyc = cyc;
                h_addr = ctrl_addr;
                h_rw   = ctrl_rw;
                h_data = ctrl_data_in;
                check("req_while_ready", 32'(ctrl_ready), 32'd1);
                if (exp_txn.size() == 0) begin
                    expire("unexpected_request");
                end else begin
                    t = exp_txn.pop_front();
                    check("txn_rw", 32'(ctrl_rw), 32'(t.rw));
                    check("txn_addr", 32'(ctrl_addr), 32'(ADDR));
                    if (t.chk_data) check("txn_data_in", 32'(ctrl_data_in), 32'(t.data));
                end
            end else if (ctrl_enable && prev_en) begin
                check("req_held_stable", 32'({ctrl_addr, ctrl_rw, ctrl_data_in}),
                      32'({h_addr, h_rw, h_data}));
            end
            if (busy && !prev_busy) begin
                busy_rises++;
                busy_rise_cyc = cyc;
            end
            if (sample_valid) begin
                sv_cnt++;
                check("sv_latency", 32'(cyc - rise_cyc), 32'd1);
                check("busy_at_publish", 32'(busy), 32'd1);
                if (exp_evt.size() == 0) begin
                    expire("unexpected_sample_valid");
                end else begin
                    e = exp_evt.pop_front();
                    check("evt_is_sample", 32'(e.is_err), 32'd0);
                    check("sample", 32'(sample), 32'(e.val));
                end
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                check("err_enable_low", 32'(ctrl_enable), 32'd0);
                if (exp_evt.size() == 0) begin
                    expire("unexpected_err");
                end else begin
                    e = exp_evt.pop_front();
                    check("evt_is_err", 32'(e.is_err), 32'd1);
                    check("sample_kept", 32'(sample), 32'(e.val));
                end
            end
            prev_en   = ctrl_enable;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic expect_txns();
        exp_txn.push_back('{rw: 1'b0, data: PTR, chk_data: 1'b1});
        exp_txn.push_back('{rw: 1'b1, data: 8'h00, chk_data: 1'b0});
        exp_txn.push_back('{rw: 1'b1, data: 8'h00, chk_data: 1'b0});
    endtask

    task automatic expect_poll(input logic [7:0] b0, input logic [7:0] b1);
        expect_txns();
        rd_bytes.push_back(b0);
        rd_bytes.push_back(b1);
        exp_evt.push_back('{is_err: 1'b0, val: {b0, b1}});
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) expire(nm);
    endtask

    task automatic wait_en(input int target, input string nm);
        int n = 0;
        while (en_rises < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (en_rises < target) expire(nm);
    endtask

    task automatic wait_err(input int target, input string nm);
        int n = 0;
        while (err_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (err_cnt < target) expire(nm);
    endtask

    task automatic check_drained(input string nm);
        check(nm, 32'(exp_txn.size() + exp_evt.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0, r0, e0, b0, lo;

        rst = 1'b1;
        poll_en = 1'b0;
        trigger = 1'b0;
        tick(3);
        check("rst_enable", 32'(ctrl_enable), 32'd0);
        check("rst_rw", 32'(ctrl_rw), 32'd0);
        check("rst_addr", 32'(ctrl_addr), 32'h45);
        check("rst_data_in", 32'(ctrl_data_in), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // Triggered poll: write pointer, two reads, sample ABCD
        s0 = sv_cnt;
        expect_poll(8'hAB, 8'hCD);
        pulse_trigger();
        wait_busy(1'b1, 10, "t1_busy_rise");
        wait_busy(1'b0, 300, "t1_busy_fall");
        tick(3);
        check("t1_sv_count", 32'(sv_cnt - s0), 32'd1);
        check_drained("t1_drained");

        // Trigger while busy is ignored
        s0 = sv_cnt;
        r0 = en_rises;
        b0 = busy_rises;
        expect_poll(8'h12, 8'h34);
        pulse_trigger();
        wait_en(r0 + 1, "t2_first_request");
        tick(5);
        pulse_trigger();
        wait_busy(1'b0, 300, "t2_busy_fall");
        tick(60);
        check("t2_sv_count", 32'(sv_cnt - s0), 32'd1);
        check("t2_one_start", 32'(busy_rises - b0), 32'd1);
        check_drained("t2_drained");

        // Controller never accepts: watchdog abort, sample kept, then normal poll
        mode = 1;
        tick(2);
        e0 = err_cnt;
        exp_txn.push_back('{rw: 1'b0, data: PTR, chk_data: 1'b1});
        exp_evt.push_back('{is_err: 1'b1, val: 16'h1234});
        pulse_trigger();
        wait_err(e0 + 1, "t4_err");
        // TMO cycles stuck in WAIT_ACC, then one cycle in ERROR before err shows
        check("t4_timeout_cycles", 32'(err_cyc - en_rise_cyc), 32'(TMO + 1));
        tick(3);
        check("t4_busy_after_err", 32'(busy), 32'd0);
        check("t4_single_err", 32'(err_cnt - e0), 32'd1);
        mode = 0;
        tick(2);
        s0 = sv_cnt;
        expect_poll(8'h55, 8'hAA);
        pulse_trigger();
        wait_busy(1'b1, 10, "t4_recover_rise");
        wait_busy(1'b0, 300, "t4_recover_fall");
        tick(3);
        check("t4_recover_sv", 32'(sv_cnt - s0), 32'd1);
        check_drained("t4_drained");

        // Ready held low: no request, then watchdog fires from ISSUE_W
        mode = 2;
        tick(2);
        r0 = en_rises;
        e0 = err_cnt;
        exp_evt.push_back('{is_err: 1'b1, val: 16'h55AA});
        pulse_trigger();
        wait_err(e0 + 1, "t5_err");
        check("t5_timeout_cycles", 32'(err_cyc - busy_rise_cyc), 32'(TMO + 1));
        check("t5_no_request", 32'(en_rises - r0), 32'd0);
        tick(3);

        // Ready low briefly: request deferred until ready returns
        s0 = sv_cnt;
        expect_poll(8'h66, 8'h77);
        pulse_trigger();
        tick(30);
        check("t5b_no_request_yet", 32'(en_rises - r0), 32'd0);
        mode = 0;
        wait_busy(1'b0, 300, "t5b_busy_fall");
        tick(3);
        check("t5b_sv", 32'(sv_cnt - s0), 32'd1);
        check_drained("t5b_drained");

        // Periodic polling: idle gap between cycles equals the period
        expect_poll(8'h01, 8'h02);
        expect_poll(8'h03, 8'h04);
        poll_en = 1'b1;
        wait_busy(1'b1, 100, "t3_first_start");
        wait_busy(1'b0, 300, "t3_first_end");
        lo = 0;
        while (busy === 1'b0 && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        check("t3_period_gap", 32'(lo), 32'(PERIOD));
        poll_en = 1'b0;
        wait_busy(1'b0, 300, "t3_second_end");
        b0 = busy_rises;
        tick(150);
        check("t3_no_start_disabled", 32'(busy_rises - b0), 32'd0);
        check_drained("t3_drained");

        // Reset during the second read's WAIT_DONE
        s0 = sv_cnt;
        r0 = en_rises;
        expect_txns();
        rd_bytes.push_back(8'hAB);
        rd_bytes.push_back(8'hCD);
        pulse_trigger();
        wait_en(r0 + 3, "t6_second_read");
        lo = 0;
        while (ctrl_enable === 1'b1 && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        tick(5);
        rst = 1'b1;
        @(negedge clk);
        check("t6_enable", 32'(ctrl_enable), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_sample_valid", 32'(sample_valid), 32'd0);
        check("t6_sample", 32'(sample), 32'd0);
        rst = 1'b0;
        tick(40);
        check("t6_no_partial", 32'(sv_cnt - s0), 32'd0);
        rd_bytes.delete();
        expect_poll(8'h9A, 8'hBC);
        pulse_trigger();
        wait_busy(1'b1, 10, "t6_restart_rise");
        wait_busy(1'b0, 300, "t6_restart_fall");
        tick(3);
        check("t6_restart_sv", 32'(sv_cnt - s0), 32'd1);
        check_drained("t6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
